tpu_axi4_result_writer: RTL and testbench

- Parametrised successor of the TPU AXI4 output path: an AXI4-Full write master that drains the systolic array's result stream to memory.
- Buffers result words in an internal FIFO and writes `cfg_num_words` words starting at `cfg_base_addr`.
- Splits the transfer into INCR bursts of at most BURST_LEN beats; no burst crosses a 4 KB boundary.
- Checks every write response; reports completion and error status to the TPU controller.

---
 rtl/tpu_axi_pkg.sv | 29 ++
 rtl/tpu_sync_fifo.sv | 57 +++++
 rtl/tpu_axi4_result_writer.sv | 183 ++++++++++++++++++
 tb/tb_tpu_axi4_result_writer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_axi_pkg.sv
// Shared AXI4 constants, writer FSM states and elaboration helpers for the TPU AXI engines.
package tpu_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam int AXI_4K = 4096;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    AW,
    W,
    B,
    DONE
  } wr_state_t;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/tpu_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; shared by the AXI write and read engines.
module tpu_sync_fifo
  import tpu_axi_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]      dout
);

  localparam int PTR_W = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full  = (r_count == (PTR_W+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // A push into a full FIFO is accepted when the same cycle pops a word.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tpu_axi4_result_writer.sv
// AXI4 write master draining the systolic-array result stream to memory in 4 KB-safe INCR bursts.
// state | meaning
// IDLE  | waiting for cfg_start
// CALC  | size next burst: min(remaining, BURST_LEN, room to 4 KB edge)
// AW    | address phase, held until FIFO holds the whole burst
// W     | data beats from FIFO head
// B     | waiting for write response
// DONE  | pulse done, return to IDLE
module tpu_axi4_result_writer
  import tpu_axi_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 1,
  parameter int AXI_ID     = 0,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                cfg_start,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic [CNT_W-1:0]    cfg_num_words,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_resp,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [ID_W-1:0]     M_AXI_AWID,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [7:0]          M_AXI_AWLEN,
  output logic [2:0]          M_AXI_AWSIZE,
  output logic [1:0]          M_AXI_AWBURST,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WLAST,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY
);

  localparam int BYTES    = DATA_W / 8;
  localparam int SIZE_LOG = clog2(BYTES);
  localparam int FCNT_W   = clog2(FIFO_DEPTH) + 1;

  wr_state_t          r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [CNT_W-1:0]   r_remain;
  logic [7:0]         r_awlen;
  logic [7:0]         r_beat;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [1:0]         r_err_resp;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [FCNT_W-1:0]  w_count;
  logic [DATA_W-1:0]  w_head;
  logic [12:0]        w_room;
  logic [12:0]        w_beats;
  logic [8:0]         w_burst_beats;
  logic               w_burst_buffered;

  tpu_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .push  (w_push),
    .din   (s_data),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .dout  (w_head)
  );

  assign s_ready = !w_full;
  assign w_push  = s_valid && !w_full;
  assign w_pop   = M_AXI_WVALID && M_AXI_WREADY;

  // Beats left before the next 4 KB page; at most 4096 / BYTES, so 13 bits suffice.
  assign w_room = (13'(AXI_4K) - {1'b0, r_addr[11:0]}) >> SIZE_LOG;

  always_comb begin
    w_beats = w_room;
    if (32'(BURST_LEN) < 32'(w_beats)) w_beats = 13'(BURST_LEN);
    if (32'(r_remain) < 32'(w_beats))  w_beats = 13'(r_remain);
  end

  assign w_burst_beats    = {1'b0, r_awlen} + 9'd1;
  assign w_burst_buffered = (32'(w_count) >= 32'(w_burst_beats));

  assign M_AXI_AWID    = ID_W'(AXI_ID);
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWLEN   = r_awlen;
  assign M_AXI_AWSIZE  = 3'(SIZE_LOG);
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_AWVALID = (r_state == AW) && w_burst_buffered;
  assign M_AXI_WDATA   = w_head;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = (r_state == W) && !w_empty;
  assign M_AXI_WLAST   = (r_state == W) && (r_beat == r_awlen);
  assign M_AXI_BREADY  = (r_state == B);

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign err_resp = r_err_resp;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_remain   <= '0;
      r_awlen    <= '0;
      r_beat     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_resp <= AXI_RESP_OKAY;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cfg_start) begin
            r_addr     <= cfg_base_addr;
            r_remain   <= cfg_num_words;
            r_err      <= 1'b0;
            r_err_resp <= AXI_RESP_OKAY;
            r_busy     <= 1'b1;
            r_state    <= (cfg_num_words == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          r_awlen <= 8'(w_beats - 13'd1);
          r_beat  <= '0;
          r_state <= AW;
        end
        AW: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) r_state <= W;
        end
        W: begin
          if (w_pop) begin
            r_beat <= r_beat + 8'd1;
            if (M_AXI_WLAST) r_state <= B;
          end
        end
        B: begin
          if (M_AXI_BVALID) begin
            if (M_AXI_BRESP != AXI_RESP_OKAY) begin
              r_err <= 1'b1;
              if (!r_err) r_err_resp <= M_AXI_BRESP;
              r_state <= DONE;
            end else begin
              r_addr   <= r_addr + (ADDR_W'(w_burst_beats) << SIZE_LOG);
              r_remain <= r_remain - CNT_W'(w_burst_beats);
              r_state  <= (r_remain == CNT_W'(w_burst_beats)) ? DONE : CALC;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_axi4_result_writer.sv
// Randomised bench for tpu_axi4_result_writer: burst plan, data order and handshake rules checked against a queue model.
module tb_tpu_axi4_result_writer;

  localparam int BYTES = 4;
  localparam int BL    = 16;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cfg_start;
  logic [31:0] cfg_base_addr;
  logic [15:0] cfg_num_words;
  logic        busy, done, err;
  logic [1:0]  err_resp;
  logic [31:0] s_data;
  logic        s_valid, s_ready;
  logic [0:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  always #5 ACLK = ~ACLK;

  tpu_axi4_result_writer dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr), .cfg_num_words(cfg_num_words),
    .busy(busy), .done(done), .err(err), .err_resp(err_resp),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  logic [31:0] q[$];
  logic [31:0] exp_addr[$];
  int          exp_len[$];
  logic [31:0] log_addr[$];
  int          log_len[$];

  bit in_burst, b_wait, b_pending, b_hs, pushed, aw_stall, w_stall, bp;
  logic [31:0] aw_prev_addr, w_prev_data;
  logic [7:0]  aw_prev_len;
  int cur_len, beat, feed_left, feed_gap, gap_cnt, err_burst, bidx;
  int done_cnt, done_cyc, first_aw_cyc, start_cyc, n_exp_aw;
  bit exp_err;
  logic [1:0] exp_resp;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Burst plan straight from the splitting rule: min(remaining, BL, room to next 4 KB page).
  task automatic plan(input logic [31:0] base, input int num);
    logic [31:0] a;
    int rem, room, beats;
    exp_addr.delete();
    exp_len.delete();
    a   = base;
    rem = num;
    while (rem > 0) begin
      room  = (4096 - int'(a % 32'd4096)) / BYTES;
      beats = rem;
      if (beats > BL)   beats = BL;
      if (beats > room) beats = room;
      exp_addr.push_back(a);
      exp_len.push_back(beats - 1);
      a   = a + 32'(beats * BYTES);
      rem = rem - beats;
    end
  endtask

  // Driver: inputs change 1 time unit after the rising edge.
  always @(posedge ACLK) begin
    cyc++;
    #1;
    if (ARESETn) begin
      if (s_valid && pushed) begin
        feed_left--;
        s_valid = 1'b0;
      end
      if (!s_valid && feed_left > 0) begin
        if (gap_cnt == 0) begin
          s_valid = 1'b1;
          s_data  = $urandom;
          gap_cnt = feed_gap;
        end else gap_cnt--;
      end
      awready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      wready  = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (bvalid && b_hs) begin
        bvalid = 1'b0;
        b_hs   = 1'b0;
      end
      if (b_pending && !bvalid && (!bp || $urandom_range(0, 1) == 1)) begin
        bvalid    = 1'b1;
        bresp     = (bidx == err_burst) ? 2'b10 : 2'b00;
        b_pending = 1'b0;
        bidx++;
      end
    end
  end

  // Compare process: everything sampled on the falling edge, i.e. what the next rising edge will see.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      pushed   = 1'b0;
      b_hs     = 1'b0;
      aw_stall = 1'b0;
      w_stall  = 1'b0;
    end else begin
      if (b_wait) check(bready, "bready_in_b", 64'(bready), 64'd1);
      else if (bready) check(1'b0, "bready_unexpected", 64'd1, 64'd0);
      if (bvalid && bready) begin
        b_hs   = 1'b1;
        b_wait = 1'b0;
        if (bresp != 2'b00) begin
          exp_addr.delete();
          exp_len.delete();
        end
      end

      if (w_stall) check(wvalid && wdata == w_prev_data, "w_stable", 64'(wdata), 64'(w_prev_data));
      if (in_burst) check(wvalid, "wvalid_gap", 64'(wvalid), 64'd1);
      else if (wvalid) check(1'b0, "w_unexpected", 64'd1, 64'd0);
      if (wvalid && wready && in_burst) begin
        if (q.size() == 0) check(1'b0, "w_underflow", 64'(wdata), 64'd0);
        else begin
          check(wdata == q[0], "wdata", 64'(wdata), 64'(q[0]));
          void'(q.pop_front());
        end
        check(wlast == (beat == cur_len), "wlast", 64'(wlast), 64'(beat == cur_len));
        if (beat == cur_len) begin
          in_burst  = 1'b0;
          b_wait    = 1'b1;
          b_pending = 1'b1;
        end
        beat++;
      end
      w_stall     = wvalid && !wready;
      w_prev_data = wdata;

      if (aw_stall)
        check(awvalid && awaddr == aw_prev_addr && awlen == aw_prev_len, "aw_stable",
              {awvalid, awlen, awaddr}, {1'b1, aw_prev_len, aw_prev_addr});
      if (awvalid) begin
        if (first_aw_cyc < 0) first_aw_cyc = cyc;
        check(exp_addr.size() != 0 && !in_burst && !b_wait, "aw_unexpected", 64'(awaddr), 64'd0);
        if (exp_addr.size() != 0) begin
          check(q.size() > exp_len[0], "aw_early", 64'(q.size()), 64'(exp_len[0] + 1));
          if (awready) begin
            check(awaddr == exp_addr[0], "awaddr", 64'(awaddr), 64'(exp_addr[0]));
            check(awlen == 8'(exp_len[0]), "awlen", 64'(awlen), 64'(exp_len[0]));
            check(awsize == 3'd2 && awburst == 2'b01 && wstrb == 4'hF && awid == 1'b0, "aw_const",
                  {awid, awsize, awburst, wstrb}, {1'b0, 3'd2, 2'b01, 4'hF});
            log_addr.push_back(awaddr);
            log_len.push_back(int'(awlen));
            cur_len = exp_len[0];
            void'(exp_addr.pop_front());
            void'(exp_len.pop_front());
            beat     = 0;
            in_burst = 1'b1;
          end
        end
      end
      aw_stall     = awvalid && !awready;
      aw_prev_addr = awaddr;
      aw_prev_len  = awlen;

      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check(!busy, "done_busy", 64'(busy), 64'd0);
      end
      pushed = s_valid && s_ready;
      if (pushed) q.push_back(s_data);
    end
  end

  task automatic check_reset_outputs();
    check(busy == 1'b0,     "rst_busy",     64'(busy),     64'd0);
    check(done == 1'b0,     "rst_done",     64'(done),     64'd0);
    check(err == 1'b0,      "rst_err",      64'(err),      64'd0);
    check(err_resp == 2'b0, "rst_err_resp", 64'(err_resp), 64'd0);
    check(awvalid == 1'b0,  "rst_awvalid",  64'(awvalid),  64'd0);
    check(wvalid == 1'b0,   "rst_wvalid",   64'(wvalid),   64'd0);
    check(wlast == 1'b0,    "rst_wlast",    64'(wlast),    64'd0);
    check(bready == 1'b0,   "rst_bready",   64'(bready),   64'd0);
    check(awaddr == 32'd0,  "rst_awaddr",   64'(awaddr),   64'd0);
    check(awlen == 8'd0,    "rst_awlen",    64'(awlen),    64'd0);
    check(s_ready == 1'b1,  "rst_s_ready",  64'(s_ready),  64'd1);
  endtask

  task automatic wait_feed_idle();
    int t = 0;
    while ((feed_left != 0 || s_valid) && t < 5000) begin
      @(negedge ACLK);
      t++;
    end
    if (t >= 5000) check(1'b0, "feed_timeout", 64'(feed_left), 64'd0);
  endtask

  // Top up the source so the FIFO model plus pending feed covers n words.
  task automatic prep(input int n, input int gap);
    wait_feed_idle();
    if (n > q.size()) begin
      feed_gap  = gap;
      gap_cnt   = 0;
      feed_left = n - q.size();
    end
  endtask

  task automatic start_xfer(input logic [31:0] base, input int num, input int eb);
    plan(base, num);
    exp_err  = (eb >= 0) && (eb < exp_addr.size());
    n_exp_aw = exp_err ? eb + 1 : exp_addr.size();
    exp_resp = exp_err ? 2'b10 : 2'b00;
    err_burst    = eb;
    bidx         = 0;
    done_cnt     = 0;
    first_aw_cyc = -1;
    log_addr.delete();
    log_len.delete();
    @(posedge ACLK); #1;
    cfg_start     = 1'b1;
    cfg_base_addr = base;
    cfg_num_words = 16'(num);
    start_cyc     = cyc;
    @(posedge ACLK); #1;
    cfg_start     = 1'b0;
    cfg_base_addr = $urandom;
    cfg_num_words = 16'($urandom);
    @(negedge ACLK);
    check(err == 1'b0, "err_cleared", 64'(err), 64'd0);
    check(busy == 1'b1, "busy_set", 64'(busy), 64'd1);
  endtask

  task automatic finish_xfer();
    int t = 0;
    while (done_cnt == 0 && t < 4000) begin
      @(negedge ACLK);
      t++;
    end
    check(done_cnt != 0, "done_timeout", 64'(t), 64'd4000);
    repeat (3) @(negedge ACLK);
    check(done_cnt == 1, "done_once", 64'(done_cnt), 64'd1);
    check(busy == 1'b0, "busy_end", 64'(busy), 64'd0);
    check(err == exp_err, "err_flag", 64'(err), 64'(exp_err));
    check(err_resp == exp_resp, "err_resp", 64'(err_resp), 64'(exp_resp));
    check(log_addr.size() == n_exp_aw, "aw_count", 64'(log_addr.size()), 64'(n_exp_aw));
    check(exp_addr.size() == 0 && !in_burst && !b_wait, "xfer_drained",
          64'(exp_addr.size()), 64'd0);
  endtask

  task automatic run(input logic [31:0] base, input int num, input int eb, input int gap);
    prep(num, gap);
    start_xfer(base, num, eb);
    finish_xfer();
  endtask

  initial begin
    logic [31:0] t1_addr [3];
    int          t1_len  [3];
    int t;
    t1_addr = '{32'h4000_0000, 32'h4000_0040, 32'h4000_0080};
    t1_len  = '{15, 15, 7};
    ARESETn = 1'b0;
    cfg_start = 1'b0; cfg_base_addr = '0; cfg_num_words = '0;
    s_valid = 1'b0; s_data = '0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
    in_burst = 0; b_wait = 0; b_pending = 0; b_hs = 0; pushed = 0; aw_stall = 0; w_stall = 0; bp = 0;
    feed_left = 0; feed_gap = 0; gap_cnt = 0; err_burst = -1; bidx = 0;
    done_cnt = 0; first_aw_cyc = -1; done_cyc = 0; start_cyc = 0;
    repeat (3) @(negedge ACLK);
    check_reset_outputs();
    @(posedge ACLK); #1;
    ARESETn = 1'b1;

    // Three bursts from a prefilled FIFO; AW two cycles after start.
    prep(40, 0);
    t = 0;
    while (q.size() < 32 && t < 500) begin
      @(negedge ACLK);
      t++;
    end
    start_xfer(32'h4000_0000, 40, -1);
    finish_xfer();
    check(first_aw_cyc - start_cyc == 2, "aw_latency", 64'(first_aw_cyc - start_cyc), 64'd2);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      check(log_addr[i] == t1_addr[i], "t1_awaddr", 64'(log_addr[i]), 64'(t1_addr[i]));
      check(log_len[i] == t1_len[i], "t1_awlen", 64'(log_len[i]), 64'(t1_len[i]));
    end

    // 4 KB page split.
    run(32'h4000_0FF0, 16, -1, 0);
    if (log_addr.size() == 2) begin
      check(log_addr[0] == 32'h4000_0FF0 && log_len[0] == 3, "t2_burst0", 64'(log_addr[0]), 64'h4000_0FF0);
      check(log_addr[1] == 32'h4000_1000 && log_len[1] == 11, "t2_burst1", 64'(log_addr[1]), 64'h4000_1000);
    end

    // Slow source: AW must wait for a whole burst of buffered words.
    run(32'h0000_1000, 32, -1, 2);
    check(first_aw_cyc - start_cyc >= 40, "slow_aw_wait", 64'(first_aw_cyc - start_cyc), 64'd40);

    // SLVERR on the second burst, then a clean transfer consuming the leftovers.
    run(32'h0000_2000, 40, 1, 0);
    wait_feed_idle();
    check(q.size() == 8, "err_leftover", 64'(q.size()), 64'd8);
    run(32'h0000_3000, 8, -1, 0);

    // Zero-length transfer.
    run(32'h0000_7000, 0, -1, 0);
    check(done_cyc - start_cyc == 2, "zero_done_latency", 64'(done_cyc - start_cyc), 64'd2);

    // Backpressure plus a start pulse while busy.
    bp = 1'b1;
    prep(50, 1);
    start_xfer(32'h5000_0F00, 50, -1);
    t = 0;
    while (log_addr.size() < 1 && t < 2000) begin
      @(negedge ACLK);
      t++;
    end
    @(posedge ACLK); #1;
    cfg_start = 1'b1; cfg_base_addr = 32'h0BAD_0000; cfg_num_words = 16'd7;
    @(posedge ACLK); #1;
    cfg_start = 1'b0;
    finish_xfer();

    for (int k = 0; k < 6; k++) begin
      int n, eb;
      bp = ($urandom_range(0, 1) == 1);
      n  = $urandom_range(1, 60);
      eb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1;
      run($urandom & 32'hFFFF_FFFC, n, eb, $urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of a W phase.
    bp = 1'b0;
    wait_feed_idle();
    prep(40, 0);
    start_xfer(32'h6000_0000, 40, -1);
    t = 0;
    while (!(in_burst && beat >= 2) && t < 2000) begin
      @(negedge ACLK);
      t++;
    end
    check(in_burst, "reached_w_phase", 64'(in_burst), 64'd1);
    @(posedge ACLK); #3;
    ARESETn = 1'b0;
    #1;
    check_reset_outputs();
    q.delete(); exp_addr.delete(); exp_len.delete();
    in_burst = 0; b_wait = 0; b_pending = 0; feed_left = 0; s_valid = 1'b0; bvalid = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    repeat (4) @(negedge ACLK);
    run(32'h6000_0000, 40, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
